sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one external asynchronous SRAM (BaseRAM-style pins) between two requesters: the IF stage (instruction reads) and the MEM stage (data reads and writes).
- Sequences multi-cycle SRAM read and write timing with an FSM and a cycle counter.
- Returns read data or write completion to the requester through a level-request / pulse-done handshake.
- Sits between the pipeline stages and the SRAM pins. The pipeline holds each stage's "over" signal low until the matching done pulse.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- RD_CYCLES, 2, cycles with ce_n/oe_n low before read data is sampled (minimum 1).
- WR_CYCLES, 2, cycles with we_n low (minimum 1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  IF read request; level, held until if_done_o.
- if_addr_i  in  ADDR_W  IF word address.
- if_rdata_o  out  32  IF read data; valid while if_done_o=1, held afterwards.
- if_done_o  out  1  one-cycle pulse: IF access complete.
- mem_req_i  in  1  MEM request; level, held until mem_done_o.
- mem_we_i  in  1  1=write, 0=read.
- mem_be_n_i  in  4  write byte enables, active-low.
- mem_addr_i  in  ADDR_W  MEM word address.
- mem_wdata_i  in  32  write data.
- mem_rdata_o  out  32  MEM read data; valid while mem_done_o=1, held afterwards.
- mem_done_o  out  1  one-cycle pulse: MEM access complete.
- busy_o  out  1  1 in any state other than IDLE.
- ram_addr_o  out  ADDR_W  SRAM address.
- ram_be_n_o  out  4  SRAM byte enables.
- ram_ce_n_o  out  1  chip enable.
- ram_oe_n_o  out  1  output enable.
- ram_we_n_o  out  1  write enable.
- ram_dq_o  out  32  write data to pad.
- ram_dq_oe_o  out  1  pad output enable; the top-level tristate uses it.
- ram_dq_i  in  32  data from pad.

Behaviour:
- Reset (async, rst_ni=0), applied immediately including mid-access:
  - state=IDLE, counter=0.
  - ce_n/oe_n/we_n=1, be_n=4'hF, dq_oe=0, addr=0, dq_o=0.
  - both done=0, both rdata=0, busy=0.
  - An aborted access produces no done pulse after reset release.
- Registered outputs: every SRAM pin output is registered, so no combinational path from a request to a pin.
- Arbitration happens only in IDLE:
  - Fixed priority: MEM beats IF (older instruction first).
  - The winner's addr, we, be_n and wdata are latched at the grant edge; inputs are ignored afterwards.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Read, MEM with we=0 or IF:
  - IDLE→RD; drive ce_n=0, oe_n=0, be_n=0000, dq_oe=0.
  - Stay RD_CYCLES cycles.
  - At the edge ending the last RD cycle: capture ram_dq_i into the owner's rdata, raise ce_n/oe_n, go to DONE.
- Write:
  - WR_SETUP, 1 cycle: ce_n=0, we_n=1, dq_oe=1, be_n=latched.
  - WR_PULSE, WR_CYCLES cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, dq_oe=1, ce_n=0.
  - Then DONE with ce_n=1, dq_oe=0.
  - A write with be_n=4'hF still runs the full cycle and completes.
- DONE, 1 cycle:
  - The owner's done=1. No grant is made, so a requester dropping req at this edge is not re-granted.
  - Next state is IDLE.
- Latency, with the request-visible IDLE cycle as cycle 0:
  - Read: done in cycle RD_CYCLES+1.
  - Write: done in cycle WR_CYCLES+3.
  - Next grant is possible in cycle latency+1.
- Simultaneous requests:
  - MEM is served first; IF is granted in the IDLE cycle right after MEM's DONE if IF is still requesting.
  - IF starvation is bounded because MEM issues at most one access per instruction.
- Protocol violations (bench must not rely on any other outcome):
  - A req dropped before done: the access still completes and done still pulses.
  - A req raised during another owner's access waits.
- Counter:
  - Width = $clog2(max(RD_CYCLES, WR_CYCLES)+1).
  - Loads 0 on state entry and increments each cycle; the state exits when the counter reaches N-1.

Decomposition:
- Package sram_arb_pkg holds:
  - the state encoding enum;
  - the owner encoding (OWN_IF, OWN_MEM);
  - DATA_W=32 and BE_W=4 constants.
- No sub-module: the counter and FSM are inline.
- The tristate pad (dq) stays in top.

Test Plan:
- IF read only, addr=0x00010, pad returns 0x02A00413 → if_done_o high in cycle 3 (RD_CYCLES=2), if_rdata_o=0x02A00413; ce_n/oe_n low in cycles 1-2, we_n always 1.
- MEM write addr=0x00040, wdata=0xDEADBEEF, be_n=4'b1100 → WR_SETUP cycle 1, we_n low in cycles 2-3, WR_HOLD cycle 4, mem_done_o in cycle 5; ram_dq_o=0xDEADBEEF with dq_oe=1 in cycles 1-4, ram_be_n_o=1100.
- IF and MEM read requested in the same cycle → MEM served first (mem_done_o in cycle 3), IF granted in cycle 4, if_done_o in cycle 7; the two rdata outputs are independent.
- Requester holds req high through DONE and drops it the cycle after done → exactly one done pulse, busy_o=0 in the following cycle, no second access.
- rst_ni asserted asynchronously in the middle of WR_PULSE → we_n/ce_n go to 1 and dq_oe to 0 without waiting for a clock edge, state=IDLE, no mem_done_o pulse after release.
- Back-to-back IF reads to 0x0,0x1,0x2 with req held continuously → done pulses in cycles 3, 7, 11, each with the matching pad data.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the SRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one asynchronous SRAM between IF reads and MEM accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_be_n_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [3:0]        ram_be_n_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic [31:0]       ram_dq_o,
    output logic              ram_dq_oe_o,
    input  logic [31:0]       ram_dq_i
);

    localparam int CNT_MAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] C_RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_WR_LAST = CNT_W'(WR_CYCLES - 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BE_W-1:0]     be_lat_q, be_lat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_q, dq_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                dq_oe_q, dq_oe_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q + CNT_W'(1);
        be_lat_d    = be_lat_q;
        addr_d      = addr_q;
        dq_d        = dq_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                // MEM holds the older instruction, so it wins a tie.
                if (mem_req_i) begin
                    owner_d = OWN_MEM;
                    addr_d  = mem_addr_i;
                    if (mem_we_i) begin
                        be_lat_d = mem_be_n_i;
                        dq_d     = mem_wdata_i;
                        state_d  = ST_WR_SETUP;
                    end else begin
                        state_d  = ST_RD;
                    end
                end else if (if_req_i) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr_i;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_q == C_RD_LAST) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = ram_dq_i;
                    end else begin
                        mem_rdata_d = ram_dq_i;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (cnt_q == C_WR_LAST) begin
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Pins are decoded from the next state so they change on the same edge.
        ce_n_d     = !(state_d inside {ST_RD, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
        oe_n_d     = (state_d != ST_RD);
        we_n_d     = (state_d != ST_WR_PULSE);
        dq_oe_d    = (state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
        be_n_d     = (state_d == ST_RD) ? '0 : (dq_oe_d ? be_lat_d : '1);
        if_done_d  = (state_d == ST_DONE) && (owner_d == OWN_IF);
        mem_done_d = (state_d == ST_DONE) && (owner_d == OWN_MEM);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            be_lat_q    <= '1;
            addr_q      <= '0;
            dq_q        <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            be_n_q      <= '1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            be_lat_q    <= be_lat_d;
            addr_q      <= addr_d;
            dq_q        <= dq_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            be_n_q      <= be_n_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_done_o   = if_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_done_o  = mem_done_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign ram_addr_o  = addr_q;
    assign ram_be_n_o  = be_n_q;
    assign ram_ce_n_o  = ce_n_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_we_n_o  = we_n_q;
    assign ram_dq_o    = dq_q;
    assign ram_dq_oe_o = dq_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed self-checking bench for sram_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_port_arbiter;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_be_n;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic [31:0]       ram_dq_o;
    logic              ram_dq_oe;
    logic [31:0]       ram_dq_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Pad model: one fixed instruction word at 0x10, address-tagged data elsewhere.
    assign ram_dq_i = (ram_addr == 20'h00010) ? 32'h02A00413 : {12'hA5A, ram_addr};

    sram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .RD_CYCLES(2),
        .WR_CYCLES(2)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_rdata_o (if_rdata),
        .if_done_o  (if_done),
        .mem_req_i  (mem_req),
        .mem_we_i   (mem_we),
        .mem_be_n_i (mem_be_n),
        .mem_addr_i (mem_addr),
        .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata),
        .mem_done_o (mem_done),
        .busy_o     (busy),
        .ram_addr_o (ram_addr),
        .ram_be_n_o (ram_be_n),
        .ram_ce_n_o (ram_ce_n),
        .ram_oe_n_o (ram_oe_n),
        .ram_we_n_o (ram_we_n),
        .ram_dq_o   (ram_dq_o),
        .ram_dq_oe_o(ram_dq_oe),
        .ram_dq_i   (ram_dq_i)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_done;
        int exp_cyc [3];
        logic [31:0] exp_dat [3];

        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be_n  = 4'hF;
        mem_addr  = '0;
        mem_wdata = '0;
        repeat (3) tick();

        chk("rst_ce_n",  {31'd0, ram_ce_n},  32'd1);
        chk("rst_oe_n",  {31'd0, ram_oe_n},  32'd1);
        chk("rst_we_n",  {31'd0, ram_we_n},  32'd1);
        chk("rst_be_n",  {28'd0, ram_be_n},  32'hF);
        chk("rst_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_done",  {30'd0, if_done, mem_done}, 32'd0);
        chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
        chk("rst_dq_o",  ram_dq_o, 32'd0);

        rst_n = 1'b1;
        tick();

        // IF read of 0x10
        if_req  = 1'b1;
        if_addr = 20'h00010;
        chk("if_c0_ce_n", {31'd0, ram_ce_n}, 32'd1);
        tick();
        chk("if_c1_ce_oe", {30'd0, ram_ce_n, ram_oe_n}, 32'd0);
        chk("if_c1_we_n",  {31'd0, ram_we_n}, 32'd1);
        chk("if_c1_addr",  {12'd0, ram_addr}, 32'h10);
        chk("if_c1_be_n",  {28'd0, ram_be_n}, 32'h0);
        chk("if_c1_busy",  {31'd0, busy}, 32'd1);
        tick();
        chk("if_c2_ce_oe", {30'd0, ram_ce_n, ram_oe_n}, 32'd0);
        chk("if_c2_done",  {31'd0, if_done}, 32'd0);
        tick();
        chk("if_c3_done",  {31'd0, if_done}, 32'd1);
        chk("if_c3_rdata", if_rdata, 32'h02A00413);
        chk("if_c3_ce_oe", {30'd0, ram_ce_n, ram_oe_n}, 32'd3);
        if_req = 1'b0;
        tick();
        chk("if_c4_done", {31'd0, if_done}, 32'd0);
        chk("if_c4_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("if_c5_busy", {31'd0, busy}, 32'd0);
        chk("if_c5_ce_n", {31'd0, ram_ce_n}, 32'd1);

        // MEM write; inputs disturbed after grant to prove they were latched
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be_n  = 4'b1100;
        mem_addr  = 20'h00040;
        mem_wdata = 32'hDEADBEEF;
        tick();
        mem_wdata = 32'h0;
        mem_be_n  = 4'b0000;
        mem_addr  = 20'h00099;
        chk("wr_c1_ce_we", {30'd0, ram_ce_n, ram_we_n}, 32'd1);
        chk("wr_c1_oe_n",  {31'd0, ram_oe_n}, 32'd1);
        chk("wr_c1_dq_oe", {31'd0, ram_dq_oe}, 32'd1);
        chk("wr_c1_dq",    ram_dq_o, 32'hDEADBEEF);
        chk("wr_c1_be_n",  {28'd0, ram_be_n}, 32'hC);
        chk("wr_c1_addr",  {12'd0, ram_addr}, 32'h40);
        tick();
        chk("wr_c2_we_n",  {31'd0, ram_we_n}, 32'd0);
        tick();
        chk("wr_c3_we_n",  {31'd0, ram_we_n}, 32'd0);
        chk("wr_c3_dq",    ram_dq_o, 32'hDEADBEEF);
        tick();
        chk("wr_c4_ce_we", {30'd0, ram_ce_n, ram_we_n}, 32'd1);
        chk("wr_c4_dq_oe", {31'd0, ram_dq_oe}, 32'd1);
        chk("wr_c4_done",  {31'd0, mem_done}, 32'd0);
        chk("wr_c4_be_n",  {28'd0, ram_be_n}, 32'hC);
        tick();
        chk("wr_c5_done",  {31'd0, mem_done}, 32'd1);
        chk("wr_c5_ce_n",  {31'd0, ram_ce_n}, 32'd1);
        chk("wr_c5_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        chk("wr_c6_done",  {31'd0, mem_done}, 32'd0);
        chk("wr_c6_busy",  {31'd0, busy}, 32'd0);

        // Simultaneous IF and MEM reads
        if_req   = 1'b1;
        if_addr  = 20'h00001;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 20'h00002;
        tick();
        chk("sim_c1_addr", {12'd0, ram_addr}, 32'h2);
        tick();
        tick();
        chk("sim_c3_mdone", {31'd0, mem_done}, 32'd1);
        chk("sim_c3_idone", {31'd0, if_done}, 32'd0);
        chk("sim_c3_mrdata", mem_rdata, 32'hA5A00002);
        chk("sim_c3_irdata", if_rdata, 32'h02A00413);
        mem_req = 1'b0;
        tick();
        chk("sim_c4_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("sim_c5_addr", {12'd0, ram_addr}, 32'h1);
        chk("sim_c5_ce_n", {31'd0, ram_ce_n}, 32'd0);
        tick();
        chk("sim_c6_idone", {31'd0, if_done}, 32'd0);
        tick();
        chk("sim_c7_idone", {31'd0, if_done}, 32'd1);
        chk("sim_c7_irdata", if_rdata, 32'hA5A00001);
        chk("sim_c7_mrdata", mem_rdata, 32'hA5A00002);
        if_req = 1'b0;
        tick();
        tick();

        // Async reset in the middle of WR_PULSE
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be_n  = 4'b0000;
        mem_addr  = 20'h00050;
        mem_wdata = 32'h12345678;
        tick();
        tick();
        chk("ar_pulse_we_n", {31'd0, ram_we_n}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we_n",  {31'd0, ram_we_n}, 32'd1);
        chk("ar_ce_n",  {31'd0, ram_ce_n}, 32'd1);
        chk("ar_dq_oe", {31'd0, ram_dq_oe}, 32'd0);
        chk("ar_busy",  {31'd0, busy}, 32'd0);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_done) n_done++;
        end
        chk("ar_no_done", n_done, 0);
        chk("ar_idle", {31'd0, busy}, 32'd0);

        // Back-to-back IF reads with request held throughout
        exp_cyc[0] = 3;  exp_dat[0] = 32'hA5A00000;
        exp_cyc[1] = 7;  exp_dat[1] = 32'hA5A00001;
        exp_cyc[2] = 11; exp_dat[2] = 32'hA5A00002;
        if_req  = 1'b1;
        if_addr = 20'h00000;
        n_done  = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (if_done) begin
                if (n_done < 3) begin
                    chk($sformatf("b2b_cyc%0d", n_done), c, exp_cyc[n_done]);
                    chk($sformatf("b2b_dat%0d", n_done), if_rdata, exp_dat[n_done]);
                end
                n_done++;
                if_addr = ADDR_W'(n_done);
                if (n_done >= 3) if_req = 1'b0;
            end
        end
        chk("b2b_count", n_done, 3);
        chk("b2b_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
